// File: rtl/axi_rd_mem_model_pkg.sv
// ---------------------------------------------------------------------------
// axi_sim_pkg
// Shared types for the AXI read-channel memory model: burst encodings,
// response codes, the queued read-request record and the read-engine state.
// REQ_ADDR_W must equal the DEPTH_LOG2 parameter of axi_rd_mem_model, since
// a queued request keeps only the in-range word address.
// ---------------------------------------------------------------------------
package axi_sim_pkg;

  localparam int unsigned REQ_ADDR_W = 10;
  localparam int unsigned LEN_W      = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]      len;
    burst_e                burst;
    logic                  err;
  } rd_req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

  // WRAP is only meaningful for 2, 4, 8 or 16 beat bursts.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    logic ok;
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/axi_rd_mem_model_if.sv
// ---------------------------------------------------------------------------
// axi_rd_mem_model_if
// AR/R channel plus backdoor load port of the read memory model.
//   master : drives araddr/arlen/arburst/arvalid, rready, ld_en/ld_addr/ld_data
//   slave  : drives arready, rdata/rresp/rlast/rvalid
// ---------------------------------------------------------------------------
interface axi_rd_mem_model_if #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned DEPTH_LOG2 = 10
);

  logic [AW-1:0]         araddr;
  logic [7:0]            arlen;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [DW-1:0]         rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic                  ld_en;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [DW-1:0]         ld_data;

  modport master (
    output araddr, arlen, arburst, arvalid, rready, ld_en, ld_addr, ld_data,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arburst, arvalid, rready, ld_en, ld_addr, ld_data,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_rd_mem_model_req_fifo.sv
// ---------------------------------------------------------------------------
// axi_sim_req_fifo
// Show-ahead synchronous FIFO of rd_req_t. A push is allowed while full if
// a pop happens in the same cycle.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data: push request
//   rd_en/rd_data: pop request / current head
//   full, empty  : occupancy flags
// ---------------------------------------------------------------------------
module axi_sim_req_fifo
  import axi_sim_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    wr_en,
  input  rd_req_t wr_data,
  input  logic    rd_en,
  output rd_req_t rd_data,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rd_req_t          mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_s;
  logic             pop_s;

  assign full    = (count_r == (PTR_W+1)'(DEPTH));
  assign empty   = (count_r == (PTR_W+1)'(0));
  assign pop_s   = rd_en && !empty;
  assign push_s  = wr_en && (!full || pop_s);
  assign rd_data = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/axi_rd_mem_model.sv
// ---------------------------------------------------------------------------
// axi_rd_mem_model
// AXI-style read-channel memory model standing in for DDR on the weight
// buffer fetch path. Requests are queued (up to OUTSTANDING) and replayed as
// FIXED/INCR/WRAP bursts with rready backpressure; out-of-range requests
// return SLVERR beats with zero data. Memory powers up as mem[i] = i and can
// be overwritten through the backdoor load port; reset never touches it.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (drops queued and in-flight bursts)
//   bus  : axi_rd_mem_model_if.slave (AR, R and backdoor load signals)
//
// Build option: define AXI_SIM_WRAP_EN to enable WRAP bursts; otherwise
// WRAP is handled as INCR and the wrap logic is left out.
// ---------------------------------------------------------------------------
module axi_rd_mem_model
  import axi_sim_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  axi_rd_mem_model_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  // Request queue
  rd_req_t               req_in_s;
  rd_req_t               req_head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  arready_s;

  // Read engine
  rd_state_e             state_r;
  rd_state_e             state_s;
  logic                  pop_s;
  logic                  adv_s;
  logic                  done_s;
  logic [DEPTH_LOG2-1:0] ptr_r;
  logic [DEPTH_LOG2-1:0] ptr_inc_s;
  logic [DEPTH_LOG2-1:0] ptr_nxt_s;
  logic [7:0]            cnt_r;
  burst_e                burst_r;
  logic                  err_r;
`ifdef AXI_SIM_WRAP_EN
  logic [7:0]            len_r;
  logic [DEPTH_LOG2-1:0] wrap_mask_s;
`endif

  // Memory and beat data
  logic [DW-1:0]         mem_r [DEPTH];
  // Two-state so it powers up cleared: a clear bit means the word still holds
  // its identity value (mem[i] = i).
  bit   [DEPTH-1:0]      loaded_r;
  logic [DEPTH_LOG2-1:0] rd_addr_s;
  logic [DW-1:0]         rd_word_s;
  logic [DW-1:0]         beat_data_s;
  logic                  beat_err_s;

  // Output registers
  logic [DW-1:0]         rdata_r;
  logic [1:0]            rresp_r;
  logic                  rlast_r;
  logic                  rvalid_r;

  assign req_in_s.addr  = bus.araddr[DEPTH_LOG2-1:0];
  assign req_in_s.len   = bus.arlen;
  assign req_in_s.burst = burst_e'(bus.arburst);
  assign req_in_s.err   = |bus.araddr[AW-1:DEPTH_LOG2];

  // A pop frees a slot in the same cycle, so arready can stay high while full.
  assign arready_s   = !rst && (!fifo_full_s || pop_s);
  assign push_s      = bus.arvalid && arready_s;
  assign bus.arready = arready_s;

  axi_sim_req_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_s),
    .wr_data (req_in_s),
    .rd_en   (pop_s),
    .rd_data (req_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Read-engine state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Read-engine next state: pop in IDLE, advance or finish on each R handshake.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    adv_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_s = ST_BURST;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        // rvalid is always high in BURST, so rready alone is the handshake.
        if (bus.rready && rlast_r) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (bus.rready) begin
          adv_s   = 1'b1;
        end else begin
          state_s = ST_BURST;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

`ifdef AXI_SIM_WRAP_EN
  assign wrap_mask_s = DEPTH_LOG2'(len_r);
`endif

  // Address of the next beat according to the burst type.
  always_comb begin
    ptr_inc_s = ptr_r + DEPTH_LOG2'(1);
    ptr_nxt_s = ptr_inc_s;
    case (burst_r)
      BURST_FIXED: ptr_nxt_s = ptr_r;
`ifdef AXI_SIM_WRAP_EN
      BURST_WRAP: begin
        // Keep the block-aligned upper bits, let only the low bits roll over.
        if (wrap_len_ok(len_r)) begin
          ptr_nxt_s = (ptr_r & ~wrap_mask_s) | (ptr_inc_s & wrap_mask_s);
        end else begin
          ptr_nxt_s = ptr_inc_s;
        end
      end
`endif
      default:     ptr_nxt_s = ptr_inc_s;
    endcase
  end

  // Beat data: first beat comes from the FIFO head, later ones from ptr_nxt.
  always_comb begin
    rd_addr_s   = pop_s ? req_head_s.addr : ptr_nxt_s;
    beat_err_s  = pop_s ? req_head_s.err  : err_r;
    rd_word_s   = loaded_r[rd_addr_s] ? mem_r[rd_addr_s] : DW'(rd_addr_s);
    beat_data_s = beat_err_s ? '0 : rd_word_s;
  end

  // Burst tracking and R-channel output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r    <= '0;
      cnt_r    <= 8'd0;
      burst_r  <= BURST_INCR;
      err_r    <= 1'b0;
      rdata_r  <= '0;
      rresp_r  <= RESP_OKAY;
      rlast_r  <= 1'b0;
      rvalid_r <= 1'b0;
    end else if (pop_s) begin
      ptr_r    <= req_head_s.addr;
      cnt_r    <= req_head_s.len;
      burst_r  <= req_head_s.burst;
      err_r    <= req_head_s.err;
      rdata_r  <= beat_data_s;
      rresp_r  <= req_head_s.err ? RESP_SLVERR : RESP_OKAY;
      rlast_r  <= (req_head_s.len == 8'd0);
      rvalid_r <= 1'b1;
    end else if (adv_s) begin
      // cnt_r counts beats still to come after the one being presented.
      ptr_r    <= ptr_nxt_s;
      cnt_r    <= cnt_r - 8'd1;
      rdata_r  <= beat_data_s;
      rlast_r  <= (cnt_r == 8'd1);
    end else if (done_s) begin
      rdata_r  <= '0;
      rresp_r  <= RESP_OKAY;
      rlast_r  <= 1'b0;
      rvalid_r <= 1'b0;
    end
  end

`ifdef AXI_SIM_WRAP_EN
  // Burst length, needed only for the wrap boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r <= 8'd0;
    end else if (pop_s) begin
      len_r <= req_head_s.len;
    end
  end
`endif

  // Backdoor load; the output register sampled this edge still sees old data.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      mem_r[bus.ld_addr]    <= bus.ld_data;
      loaded_r[bus.ld_addr] <= 1'b1;
    end
  end

  assign bus.rdata  = rdata_r;
  assign bus.rresp  = rresp_r;
  assign bus.rlast  = rlast_r;
  assign bus.rvalid = rvalid_r;

endmodule

// File: tb/tb_axi_rd_mem_model.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_mem_model
// Directed bench for axi_rd_mem_model: burst types, latency, backpressure,
// queue-full behaviour, error responses, backdoor load and mid-burst reset.
// ---------------------------------------------------------------------------
module tb_axi_rd_mem_model;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axi_rd_mem_model_if #(.DW(32), .AW(32), .DEPTH_LOG2(10)) bus ();

  axi_rd_mem_model #(
    .DW          (32),
    .AW          (32),
    .DEPTH_LOG2  (10),
    .OUTSTANDING (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec   = 0;
  int          n_err   = 0;
  int          cyc_cnt = 0;
  int          waits;
  int          acc_cyc;
  int          end_cyc;
  bit          got_it;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold arvalid until accepted; returns one cycle after the handshake cycle.
  task automatic send_req(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output int nwait);
    bit done = 1'b0;
    nwait = 0;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (bus.arready) done = 1'b1;
      else nwait++;
      tick();
    end
    bus.arvalid = 1'b0;
    check_val("ar_accept", done, 1);
  endtask

  // Expect rvalid low for exactly this cycle.
  task automatic check_gap(input string tag);
    @(negedge clk);
    check_val(tag, bus.rvalid, 0);
    tick();
  endtask

  // Consume exp_q.size() beats; rready follows pat (bit per cycle).
  task automatic collect(input string tag, input logic [1:0] resp,
                         input logic [15:0] pat, input bit expect_now);
    int i = 0;
    int n = exp_q.size();
    for (int c = 0; c < 400 && i < n; c++) begin
      bus.rready = pat[c % 16];
      @(negedge clk);
      if (c == 0 && expect_now) check_val({tag, "_first_valid"}, bus.rvalid, 1);
      if (bus.rvalid) begin
        check_val({tag, "_data"}, bus.rdata, exp_q[i]);
        check_val({tag, "_last"}, bus.rlast, (i == n - 1));
        check_val({tag, "_resp"}, bus.rresp, resp);
        if (bus.rready) i++;
      end
      tick();
    end
    check_val({tag, "_count"}, i, n);
    bus.rready = 1'b1;
  endtask

  task automatic run_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [1:0] resp, input logic [15:0] pat);
    int nw;
    send_req(addr, len, burst, nw);
    check_val({tag, "_arwait"}, nw, 0);
    check_gap({tag, "_latency_gap"});
    collect(tag, resp, pat, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.araddr  = 32'h0;
    bus.arlen   = 8'h0;
    bus.arburst = 2'b01;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    bus.ld_en   = 1'b0;
    bus.ld_addr = 10'h0;
    bus.ld_data = 32'h0;
    tick();
    tick();
    @(negedge clk);
    check_val("rst_arready", bus.arready, 0);
    check_val("rst_rvalid",  bus.rvalid,  0);
    check_val("rst_rlast",   bus.rlast,   0);
    check_val("rst_rresp",   bus.rresp,   0);
    check_val("rst_rdata",   bus.rdata,   0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_arready", bus.arready, 1);
    check_val("post_rst_rvalid",  bus.rvalid,  0);
    tick();

    // INCR, latency and rlast position
    exp_q = '{32'h10, 32'h11, 32'h12, 32'h13};
    run_burst("incr", 32'h10, 8'd3, 2'b01, 2'b00, 16'hFFFF);

    // WRAP (INCR when the wrap feature is compiled out)
`ifdef AXI_SIM_WRAP_EN
    exp_q = '{32'h0E, 32'h0F, 32'h0C, 32'h0D};
`else
    exp_q = '{32'h0E, 32'h0F, 32'h10, 32'h11};
`endif
    run_burst("wrap", 32'h0E, 8'd3, 2'b10, 2'b00, 16'hFFFF);

    exp_q = '{32'h3FF, 32'h3FF, 32'h3FF};
    run_burst("fixed", 32'h3FF, 8'd2, 2'b00, 2'b00, 16'hFFFF);

    exp_q = '{32'h3FE, 32'h3FF, 32'h000, 32'h001};
    run_burst("incr_rollover", 32'h3FE, 8'd3, 2'b01, 2'b00, 16'hFFFF);

    exp_q = '{32'h3FE, 32'h3FF};
    run_burst("rsvd", 32'h3FE, 8'd1, 2'b11, 2'b00, 16'hFFFF);

    // Backpressure: rready 1,0,0,1 repeating
    exp_q = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107};
    run_burst("stall", 32'h100, 8'd7, 2'b01, 2'b00, 16'h9999);

    // Queue full: one burst in flight (stalled) plus four queued, sixth held
    bus.rready = 1'b0;
    send_req(32'h20, 8'd1, 2'b01, waits);
    check_val("q_r1_wait", waits, 0);
    send_req(32'h30, 8'd0, 2'b00, waits);
    check_val("q_r2_wait", waits, 0);
    send_req(32'h40, 8'd2, 2'b01, waits);
    check_val("q_r3_wait", waits, 0);
    send_req(32'h50, 8'd0, 2'b01, waits);
    check_val("q_r4_wait", waits, 0);
    send_req(32'h60, 8'd1, 2'b01, waits);
    check_val("q_r5_wait", waits, 0);
    bus.araddr  = 32'h70;
    bus.arlen   = 8'd0;
    bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    @(negedge clk);
    check_val("q_full_arready", bus.arready, 0);
    tick();
    got_it  = 1'b0;
    acc_cyc = -1;
    end_cyc = -2;
    fork
      begin
        for (int k = 0; k < 100 && !got_it; k++) begin
          @(negedge clk);
          if (bus.arready) begin
            got_it  = 1'b1;
            acc_cyc = cyc_cnt;
            check_val("q_accept_in_gap", bus.rvalid, 0);
          end
          tick();
        end
        bus.arvalid = 1'b0;
      end
      begin
        exp_q = '{32'h20, 32'h21};
        collect("q_r1", 2'b00, 16'hFFFF, 1'b1);
        end_cyc = cyc_cnt;
      end
    join
    check_val("q_r6_accepted", got_it, 1);
    check_val("q_r6_on_pop", acc_cyc, end_cyc);
    exp_q = '{32'h30};
    collect("q_r2", 2'b00, 16'hFFFF, 1'b1);
    check_gap("q_gap3");
    exp_q = '{32'h40, 32'h41, 32'h42};
    collect("q_r3", 2'b00, 16'hFFFF, 1'b1);
    check_gap("q_gap4");
    exp_q = '{32'h50};
    collect("q_r4", 2'b00, 16'hFFFF, 1'b1);
    check_gap("q_gap5");
    exp_q = '{32'h60, 32'h61};
    collect("q_r5", 2'b00, 16'hFFFF, 1'b1);
    check_gap("q_gap6");
    exp_q = '{32'h70};
    collect("q_r6", 2'b00, 16'hFFFF, 1'b1);

    // Out-of-range request
    exp_q = '{32'h0, 32'h0};
    run_burst("slverr", 32'h400, 8'd1, 2'b01, 2'b10, 16'hFFFF);

    // Backdoor load then read back
    bus.ld_en   = 1'b1;
    bus.ld_addr = 10'd5;
    bus.ld_data = 32'hDEAD;
    tick();
    bus.ld_en   = 1'b0;
    exp_q = '{32'hDEAD, 32'h6};
    run_burst("backdoor", 32'h5, 8'd1, 2'b01, 2'b00, 16'hFFFF);

    // Reset in the middle of a stalled burst
    bus.rready = 1'b0;
    send_req(32'h100, 8'd7, 2'b01, waits);
    check_gap("mid_rst_gap");
    @(negedge clk);
    check_val("mid_rst_pre_valid", bus.rvalid, 1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_val("mid_rst_rvalid",  bus.rvalid,  0);
    check_val("mid_rst_arready", bus.arready, 0);
    check_val("mid_rst_rdata",   bus.rdata,   0);
    check_val("mid_rst_rlast",   bus.rlast,   0);
    tick();
    rst = 1'b0;
    bus.rready = 1'b1;
    @(negedge clk);
    check_val("mid_rst_rel_arready", bus.arready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("mid_rst_no_resume", bus.rvalid, 0);
      tick();
    end
    exp_q = '{32'h200};
    run_burst("after_rst", 32'h200, 8'd0, 2'b01, 2'b00, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
